jk_seq_ctrl: RTL

//   Sequencer for a WIDTH-bit bank of JK flip-flops: computes per-bit J/K each cycle to hold, load, count up or count down.

---
 rtl/jk_ctrl_pkg.sv | 38 +++
 rtl/jk_cell.sv | 31 +++
 rtl/jk_seq_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/jk_ctrl_pkg.sv
// Shared types and constants for the JK bank sequencer.
// Contents: mode_e (operation requested on start), state_e (controller
// state), drv_e (bank drive selection), the {J,K} pair codes and a helper
// that turns a data bit into the {J,K} pair that loads it.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_UP   = 2'b10,
        MODE_DOWN = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        DRV_HOLD = 2'b00,
        DRV_LOAD = 2'b01,
        DRV_UP   = 2'b10,
        DRV_DOWN = 2'b11
    } drv_e;

    // {J,K} pair codes
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    function automatic logic [1:0] jk_load(input logic d);
        return d ? JK_SET : JK_RESET;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop of the storage bank.
// Ports: CLK rising-edge clock, CLR async active-low clear,
//        j/k per-cell inputs, q stored bit.
module jk_cell
    import jk_ctrl_pkg::*;
(
    input  logic CLK,
    input  logic CLR,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_RESET:  r_q <= 1'b0;
                JK_SET:    r_q <= 1'b1;
                JK_TOGGLE: r_q <= ~r_q;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequencer for a WIDTH-bit bank of JK flip-flops. Each cycle it picks
// per-bit J/K to hold, load, count up or count down the bank, with a
// start/busy/done handshake; a run ends when the bank reaches the limit.
// Ports: CLK clock, CLR async active-low reset, start/abort/pause controls,
//        mode/load_val/limit (latched on accepted start), q bank state,
//        busy (LOAD or RUN), done (one-cycle pulse), wrap (reload pulse).
// Build option: define JKC_WRAP_EN to make a run reload load_val at the
// limit (pulsing wrap) instead of finishing; otherwise wrap is tied 0.
//
// state  | meaning
// S_IDLE | bank held, waiting for start
// S_LOAD | bank takes latched load_val at the next edge
// S_RUN  | bank counts up/down until it equals the latched limit
// S_DONE | done pulse for one cycle, then back to idle
module jk_seq_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e           r_state;
    state_e           w_state_nxt;
    mode_e            r_mode;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] r_limit;
    logic             w_accept;
    drv_e             w_drv;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_up_en;
    logic [WIDTH-1:0] w_dn_en;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
`ifdef JKC_WRAP_EN
    logic             w_wrap;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state    <= S_IDLE;
            r_mode     <= MODE_HOLD;
            r_load_val <= '0;
            r_limit    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mode     <= mode_e'(mode);
                r_load_val <= load_val;
                r_limit    <= limit;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drv       = DRV_HOLD;
`ifdef JKC_WRAP_EN
        w_wrap      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_accept = 1'b1;
                    case (mode_e'(mode))
                        MODE_LOAD:          w_state_nxt = S_LOAD;
                        MODE_UP, MODE_DOWN: w_state_nxt = S_RUN;
                        default:            w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_drv       = DRV_LOAD;
                    w_state_nxt = S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!pause) begin
                    // Compare before stepping: reaching the limit costs one
                    // extra cycle, and a run starting at the limit takes no step.
                    if (w_q == r_limit) begin
`ifdef JKC_WRAP_EN
                        w_drv  = DRV_LOAD;
                        w_wrap = 1'b1;
`else
                        w_state_nxt = S_DONE;
`endif
                    end else begin
                        w_drv = (r_mode == MODE_DOWN) ? DRV_DOWN : DRV_UP;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Toggle-enable chains: bit i toggles when all lower bits are 1 (up)
    // or all lower bits are 0 (down); bit 0 always toggles.
    always_comb begin : p_chain
        logic v_up;
        logic v_dn;
        v_up = 1'b1;
        v_dn = 1'b1;
        w_up_en = '0;
        w_dn_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_en[i] = v_up;
            w_dn_en[i] = v_dn;
            v_up = v_up & w_q[i];
            v_dn = v_dn & ~w_q[i];
        end
    end

    always_comb begin : p_jk
        logic [1:0] v_jk;
        w_j = '0;
        w_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            v_jk = JK_HOLD;
            case (w_drv)
                DRV_LOAD: v_jk = jk_load(r_load_val[i]);
                DRV_UP:   v_jk = w_up_en[i] ? JK_TOGGLE : JK_HOLD;
                DRV_DOWN: v_jk = w_dn_en[i] ? JK_TOGGLE : JK_HOLD;
                default:  v_jk = JK_HOLD;
            endcase
            w_j[i] = v_jk[1];
            w_k[i] = v_jk[0];
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .CLK (CLK),
            .CLR (CLR),
            .j   (w_j[gi]),
            .k   (w_k[gi]),
            .q   (w_q[gi])
        );
    end

    assign q    = w_q;
    assign busy = (r_state == S_LOAD) || (r_state == S_RUN);
    // abort in DONE suppresses the pulse as well as returning to idle
    assign done = (r_state == S_DONE) && !abort;
`ifdef JKC_WRAP_EN
    assign wrap = w_wrap;
`else
    assign wrap = 1'b0;
`endif

endmodule
